// File: rtl/n_way_traffic_controller.sv
// N-way traffic-light sequencer: green -> yellow -> all-red per way, advancing on a one-cycle tick strobe.
// Optional feature macro PED_REQ_EN: walk lamps only light for latched pedestrian requests.
module n_way_traffic_controller #(
  parameter int N_WAYS       = 4,
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1,
  parameter int CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick,
  input  logic [N_WAYS-1:0]           ped_req,
  output logic [3*N_WAYS-1:0]         lights,
  output logic [N_WAYS-1:0]           walk,
  output logic [$clog2(N_WAYS)-1:0]   active,
  output logic [1:0]                  phase
);

  localparam int AW = $clog2(N_WAYS);

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [AW-1:0]    active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    next_way;
  logic             enter_green;
  logic             walk_bit;

  always_comb begin
    next_way = (active_q == AW'(N_WAYS - 1)) ? '0 : active_q + AW'(1);
  end

  always_comb begin
    phase_d     = phase_q;
    active_d    = active_q;
    cnt_d       = cnt_q;
    enter_green = 1'b0;
    if (tick) begin
      case (phase_q)
        PH_ALLRED: begin
          if (cnt_q == CNT_W'(ALLRED_TICKS - 1)) begin
            phase_d     = PH_GREEN;
            cnt_d       = '0;
            enter_green = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_GREEN: begin
          if (cnt_q == CNT_W'(GREEN_TICKS - 1)) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == CNT_W'(YELLOW_TICKS - 1)) begin
            phase_d  = PH_ALLRED;
            cnt_d    = '0;
            active_d = next_way;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          phase_d = PH_ALLRED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_ALLRED;
      active_q <= '0;
      cnt_q    <= '0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef PED_REQ_EN
  logic [N_WAYS-1:0] pending_q, pending_d;
  logic              granted_q, granted_d;

  // Grant reads the old pending bit; a request in the grant cycle stays latched for next rotation.
  always_comb begin
    pending_d = pending_q;
    granted_d = granted_q;
    if (enter_green) begin
      granted_d           = pending_q[next_way];
      pending_d[next_way] = 1'b0;
    end
    pending_d = pending_d | ped_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      granted_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      granted_q <= granted_d;
    end
  end

  assign walk_bit = granted_q;
`else
  logic unused_ped;
  logic unused_enter;
  assign unused_ped   = ^ped_req;
  assign unused_enter = enter_green;
  assign walk_bit     = 1'b1;
`endif

  always_comb begin
    lights = '0;
    walk   = '0;
    for (int i = 0; i < N_WAYS; i++) begin
      lights[3*i +: 3] = 3'b001;
      if (AW'(i) == active_q) begin
        if (phase_q == PH_GREEN)       lights[3*i +: 3] = 3'b100;
        else if (phase_q == PH_YELLOW) lights[3*i +: 3] = 3'b010;
      end
    end
    if (phase_q == PH_GREEN || phase_q == PH_YELLOW) walk[next_way] = walk_bit;
  end

  assign active = active_q;
  assign phase  = phase_q;

endmodule

// File: tb/tb_n_way_traffic_controller.sv
// Scoreboard bench for n_way_traffic_controller; expected outputs come from a tick-position model.
module tb_n_way_traffic_controller;

  localparam int N  = 4;
  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int A  = 1;
  localparam int L  = G + Y + A;
  localparam int AW = $clog2(N);
  localparam int OW = 3*N + N + AW + 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tick;
  logic [N-1:0]     ped_req;
  logic [3*N-1:0]   lights;
  logic [N-1:0]     walk;
  logic [AW-1:0]    active;
  logic [1:0]       phase;

  n_way_traffic_controller #(
    .N_WAYS(N), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ped_req(ped_req),
    .lights(lights), .walk(walk), .active(active), .phase(phase)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int           m_t;
  logic [N-1:0] m_pend;
  logic         m_grant;
  logic [OW-1:0] sb[$];
  logic [OW-1:0] obs, exp_v;

  localparam logic [OW-1:0] RST_OUT = {12'h249, 4'h0, 2'd0, 2'b00};

  // Position within the rotation decides everything: slot = way, offset = phase/count.
  function automatic logic [OW-1:0] model_out();
    int o, s, k;
    logic [1:0]     ph;
    logic [3*N-1:0] lt;
    logic [N-1:0]   wk;
    o  = m_t % L;
    s  = (m_t / L) % N;
    k  = (s + 1) % N;
    ph = (o < A) ? 2'b00 : (o < A + G) ? 2'b01 : 2'b10;
    lt = '0;
    wk = '0;
    for (int i = 0; i < N; i++) begin
      if (i == s && ph == 2'b01)      lt[3*i +: 3] = 3'b100;
      else if (i == s && ph == 2'b10) lt[3*i +: 3] = 3'b010;
      else                            lt[3*i +: 3] = 3'b001;
    end
`ifdef PED_REQ_EN
    if (ph != 2'b00) wk[k] = m_grant;
`else
    if (ph != 2'b00) wk[k] = 1'b1;
`endif
    return {lt, wk, AW'(s), ph};
  endfunction

  task automatic drive(input logic tk, input logic [N-1:0] pr);
    @(negedge clk);
    tick    = tk;
    ped_req = pr;
    if (tk) begin
      m_t++;
`ifdef PED_REQ_EN
      if (m_t % L == A) begin
        m_grant = m_pend[((m_t / L) % N + 1) % N];
        m_pend[((m_t / L) % N + 1) % N] = 1'b0;
      end
`endif
    end
`ifdef PED_REQ_EN
    m_pend = m_pend | pr;
`endif
    sb.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    tick    = 1'b0;
    ped_req = '0;
    m_t     = 0;
    m_pend  = '0;
    m_grant = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    tick    = 1'b0;
    ped_req = '0;
    #1;
    obs = {lights, walk, active, phase};
    n_cmp++;
    if (obs !== RST_OUT) begin
      n_bad++;
      $display("FAIL reset_initial got %h want %h", obs, RST_OUT);
    end
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    obs = {lights, walk, active, phase};
    n_cmp++;
    if (obs !== RST_OUT) begin
      n_bad++;
      $display("FAIL reset_hold_tick got %h want %h", obs, RST_OUT);
    end
    apply_reset();
    #1;
    obs = {lights, walk, active, phase};
    n_cmp++;
    if (obs !== RST_OUT) begin
      n_bad++;
      $display("FAIL reset_release got %h want %h", obs, RST_OUT);
    end
  endtask

  task automatic test_sequence();
    apply_reset();
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, '0);
      obs   = {lights, walk, active, phase};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL seq t=%0d got %h want %h", m_t, obs, exp_v);
      end
      if (m_t == 29) begin
        n_cmp++;
        if (lights[2:0] !== 3'b100 || active !== 2'd0) begin
          n_bad++;
          $display("FAIL wrap_green got lamp0=%b active=%0d want 100/0", lights[2:0], active);
        end
      end
    end
  endtask

  task automatic test_slow_tick();
    apply_reset();
    for (int c = 0; c < 90; c++) begin
      drive((c % 3) == 2, '0);
      obs   = {lights, walk, active, phase};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL slow c=%0d got %h want %h", c, obs, exp_v);
      end
    end
  endtask

`ifndef PED_REQ_EN
  task automatic test_walk_default();
    int walk_cnt;
    walk_cnt = 0;
    apply_reset();
    for (int c = 0; c < L; c++) begin
      drive(1'b1, '0);
      if (walk === 4'b0010) walk_cnt++;
      obs   = {lights, walk, active, phase};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL walk_def t=%0d got %h want %h", m_t, obs, exp_v);
      end
    end
    n_cmp++;
    if (walk_cnt != G + Y) begin
      n_bad++;
      $display("FAIL walk_len got %0d want %0d", walk_cnt, G + Y);
    end
  endtask
`else
  task automatic test_ped();
    logic [N-1:0] pr;
    int w2_cnt;
    w2_cnt = 0;
    apply_reset();
    for (int c = 0; c < 2*N*L + 4; c++) begin
      pr = '0;
      if (c == 2) pr[2] = 1'b1;
      if (c == 3) pr[1] = 1'b1;
      if (c == 35) pr[3] = 1'b1;
      drive(1'b1, pr);
      if (m_t >= L + A && m_t < 2*L && walk[2] === 1'b1) w2_cnt++;
      obs   = {lights, walk, active, phase};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL ped t=%0d got %h want %h", m_t, obs, exp_v);
      end
      if (m_t < N*L) begin
        n_cmp++;
        if (walk[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL walk1_first_rot t=%0d got %b want 0", m_t, walk[1]);
        end
      end
    end
    n_cmp++;
    if (w2_cnt != G + Y) begin
      n_bad++;
      $display("FAIL walk2_len got %0d want %0d", w2_cnt, G + Y);
    end
  endtask
`endif

  task automatic test_async_reset();
    apply_reset();
    for (int c = 0; c < 2*L + A + G + 1; c++) begin
      drive(1'b1, '0);
      exp_v = sb.pop_front();
    end
    obs = {lights, walk, active, phase};
    n_cmp++;
    if (obs !== exp_v || phase !== 2'b10 || active !== 2'd2) begin
      n_bad++;
      $display("FAIL pre_reset_yellow2 got %h want %h", obs, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {lights, walk, active, phase};
    n_cmp++;
    if (obs !== RST_OUT) begin
      n_bad++;
      $display("FAIL async_reset got %h want %h", obs, RST_OUT);
    end
    apply_reset();
    drive(1'b1, '0);
    obs   = {lights, walk, active, phase};
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs !== exp_v || lights[2:0] !== 3'b100) begin
      n_bad++;
      $display("FAIL post_reset_way0 got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_slow_tick();
`ifndef PED_REQ_EN
    test_walk_default();
`else
    test_ped();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/n_way_traffic_controller.md
# n_way_traffic_controller

Parametrised N-way traffic-light sequencer with per-approach green/yellow/all-red timing and pedestrian walk outputs. Way `i` gets green, then yellow, then an all-red clearance interval, then way `i+1` takes over, wrapping after the last way. The block advances only on an external one-cycle `tick` strobe produced by the board clock divider, so the block itself runs on the fast system clock. It drives the lamp and walk outputs of the FPGA intersection top level.

## Interface
- `N_WAYS`, 4: number of approaches, legal range 2..8.
- `GREEN_TICKS`, 4: green duration in ticks, must be ≥1.
- `YELLOW_TICKS`, 2: yellow duration in ticks, must be ≥1.
- `ALLRED_TICKS`, 1: all-red clearance in ticks, must be ≥1.
- `CNT_W`, 8: tick-counter width. Every duration must be ≤ 2^CNT_W.

- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle advance strobe, synchronous to `clk`.
- `ped_req` input N_WAYS: pedestrian request buttons, one bit per crossing. Used only with `PED_REQ_EN`.
- `lights` output 3*N_WAYS: per way `i`, bit `[3i+2]` = green, `[3i+1]` = yellow, `[3i]` = red.
- `walk` output N_WAYS: pedestrian walk lamps.
- `active` output $clog2(N_WAYS): index of the way that currently owns or next owns the green.
- `phase` output 2: current phase. 00 = ALLRED, 01 = GREEN, 10 = YELLOW. 11 is unused.

## Operation
- State registers:
  - `phase`
  - `active`
  - `cnt` (CNT_W bits)
  - `pending` (N_WAYS bits, with macro only)
- Reset values: phase = ALLRED, active = 0, cnt = 0, pending = 0.
- Outputs are decoded from the registered state only. There is no combinational path from inputs to outputs.
- Reset output values:
  - `lights`: every way reads 3'b001.
  - `walk`: all 0.
  - `active`: 0.
  - `phase`: 00.
- Transitions are evaluated only in cycles where `tick` = 1. With `tick` = 0 all state holds.
- Phase progression:
  - ALLRED: if cnt == ALLRED_TICKS-1, go to GREEN and set cnt = 0. Otherwise cnt+1.
  - GREEN: if cnt == GREEN_TICKS-1, go to YELLOW and set cnt = 0. Otherwise cnt+1.
  - YELLOW: if cnt == YELLOW_TICKS-1, go to ALLRED, set cnt = 0, and set active = (active == N_WAYS-1) ? 0 : active+1. Otherwise cnt+1.
- Lamp decode:
  - Way `active` shows 3'b100 in GREEN and 3'b010 in YELLOW.
  - Every other way, and every way in ALLRED, shows 3'b001.
  - Exactly one lamp bit is set per way at all times.
- Walk decode:
  - `walk[(active+1) mod N_WAYS]` may be high only during GREEN and YELLOW of `active`.
  - All other walk bits are 0.
  - Gating of that bit is set by `PED_REQ_EN` (see Configuration).
- Each phase lasts exactly its parameter's number of ticks. One full rotation lasts N_WAYS*(GREEN_TICKS+YELLOW_TICKS+ALLRED_TICKS) ticks.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Way 0 is the first green after release.

## Timing
- State changes on the `clk` edge at which `tick` = 1. Outputs reflect the new state in that same cycle, i.e. one clock after the strobe is sampled.
- From reset release with `tick` held high, the first green appears after ALLRED_TICKS cycles.
- `ped_req` is sampled every `clk` cycle, not only on ticks. A pulse of 1 clock is sufficient.
- If a request arrives in the same cycle as the GREEN-entry grant for that bit:
  - the grant uses the old `pending` value;
  - the new request stays pending for the next rotation.

## Configuration
- Macro: `PED_REQ_EN`.
- Without the macro:
  - `ped_req` is ignored and the `pending` register is not built.
  - The walk bit is high for the whole GREEN+YELLOW of every phase.
- With the macro:
  - Any cycle with `ped_req[k]` = 1 sets `pending[k]`, which is sticky.
  - On the tick that enters GREEN for way `a`, with k = (a+1) mod N_WAYS: `granted[k]` = `pending[k]`, then `pending[k]` is cleared if it was set.
  - `walk[k]` is high during that GREEN+YELLOW only if `granted[k]` = 1.
  - A request made during its own crossing's phase is served on the next rotation.

## Test plan
- Default parameters, reset released, `tick` = 1 every cycle:
  - `lights` = 12'h249 for 1 cycle;
  - then way 0 = 3'b100 for 4 cycles and 3'b010 for 2 cycles;
  - then all red for 1 cycle;
  - then way 1 green with `active` = 1.
- Run for 28 ticks: `active` sequence is 0,1,2,3 and wraps back to 0; way 0 green again at tick 29.
- `tick` pulsed every 3rd cycle: every phase lasts exactly 3× its tick count in cycles; no output changes in non-tick cycles.
- Without `PED_REQ_EN`: during way 0 GREEN+YELLOW, `walk` = 4'b0010 for exactly 6 ticks, then 0 during ALLRED.
- With `PED_REQ_EN`:
  - A 1-cycle `ped_req[2]` pulse during way 0 green gives `walk[2]` = 1 for the 6 ticks of way 1's phase.
  - `walk[1]` stays 0 throughout.
  - A `ped_req[1]` pulse during way 0 green is served only in the next rotation.
- Assert `rst_n` = 0 mid-yellow of way 2, between clock edges: outputs go immediately to `lights` = 12'h249, `walk` = 0, `active` = 0, `phase` = 00.
